pc_fetch_stage: RTL and testbench

Instruction-fetch stage placed directly downstream of the branch/jump resolution logic. It consumes the PCSrc/PCNew redirect pair and owns the program counter. It drives the instruction-memory address and registers the fetched word plus PC+4 into the IF/ID pipeline register. It handles stalls from the hazard unit, including a redirect that arrives during a stall, and flushes wrong-path instructions.

---
 rtl/pc_fetch_stage_if.sv | 36 +++
 rtl/pc_fetch_stage.sv | 127 ++++++++++++
 tb/tb_pc_fetch_stage.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/pc_fetch_stage_if.sv
// ============================================================================
//  Module      : pc_fetch_stage_if
//  Description : Bundle between branch resolution / hazard unit / instruction
//                memory and the instruction-fetch stage.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface pc_fetch_stage_if;
    logic [1:0]  PCSrc;
    logic [31:0] PCNew;
    logic        Stall;
    logic [31:0] Instruction;
    logic [31:0] InstrAddr;
    logic [31:0] IFID_Instr;
    logic [31:0] IFID_PCPlus4;
    logic        IFID_Valid;
    logic        RedirectPending;
    logic        AlignErr;

    // Environment side: redirect/stall control and memory read data
    modport master (
        output PCSrc, PCNew, Stall, Instruction,
        input  InstrAddr, IFID_Instr, IFID_PCPlus4, IFID_Valid,
               RedirectPending, AlignErr
    );

    // Fetch stage side
    modport slave (
        input  PCSrc, PCNew, Stall, Instruction,
        output InstrAddr, IFID_Instr, IFID_PCPlus4, IFID_Valid,
               RedirectPending, AlignErr
    );
endinterface

`default_nettype wire

// File: rtl/pc_fetch_stage.sv
// ============================================================================
//  Module      : pc_fetch_stage
//  Description : Instruction-fetch stage. Owns the PC, applies branch/jump
//                redirects (deferring them across hazard stalls), and loads
//                the IF/ID pipeline register, flushing wrong-path words.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pc_fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  wire logic         Clk,
    input  wire logic         Reset,
    pc_fetch_stage_if.slave   bus
);

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_PEND = 1'b1
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    logic [31:0] r_pc;
    logic [31:0] r_pend;
    logic [31:0] r_ifid_instr;
    logic [31:0] r_ifid_pc4;
    logic        r_ifid_valid;
    logic        r_align_err;

    logic [31:0] w_pc_nxt;
    logic [31:0] w_pend_nxt;
    logic [31:0] w_ifid_instr_nxt;
    logic [31:0] w_ifid_pc4_nxt;
    logic        w_ifid_valid_nxt;
    logic        w_align_err_nxt;

    logic        w_redirect;
    logic [31:0] w_target;
    logic [31:0] w_pc_plus4;

    // Only PCSrc==1 redirects; the low target bits are dropped so fetch stays word aligned
    assign w_redirect = (bus.PCSrc == 2'b01);
    assign w_target   = {bus.PCNew[31:2], 2'b00};
    assign w_pc_plus4 = r_pc + 32'd4;

    // Next-state and next-datapath selection, highest-priority case first
    always_comb begin
        w_state_nxt      = r_state;
        w_pc_nxt         = r_pc;
        w_pend_nxt       = r_pend;
        w_ifid_instr_nxt = r_ifid_instr;
        w_ifid_pc4_nxt   = r_ifid_pc4;
        w_ifid_valid_nxt = r_ifid_valid;
        w_align_err_nxt  = r_align_err | (w_redirect & (bus.PCNew[1:0] != 2'b00));

        if (w_redirect && !bus.Stall) begin
            // Apply immediately; any older deferred target is obsolete
            w_pc_nxt         = w_target;
            w_pend_nxt       = 32'h0000_0000;
            w_ifid_instr_nxt = NOP_INSTR;
            w_ifid_valid_nxt = 1'b0;
            w_state_nxt      = ST_RUN;
        end else if (w_redirect) begin
            // Stalled: remember the newest target, flush even though stalled
            w_pend_nxt       = w_target;
            w_ifid_instr_nxt = NOP_INSTR;
            w_ifid_valid_nxt = 1'b0;
            w_state_nxt      = ST_PEND;
        end else if (r_state == ST_PEND) begin
            if (!bus.Stall) begin
                // Stall released: jump to the deferred target, current word is stale
                w_pc_nxt         = r_pend;
                w_ifid_instr_nxt = NOP_INSTR;
                w_ifid_valid_nxt = 1'b0;
                w_state_nxt      = ST_RUN;
            end
        end else if (!bus.Stall) begin
            // Sequential fetch
            w_pc_nxt         = w_pc_plus4;
            w_ifid_instr_nxt = bus.Instruction;
            w_ifid_pc4_nxt   = w_pc_plus4;
            w_ifid_valid_nxt = 1'b1;
        end
    end

    // State register
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // PC, deferred target, IF/ID register and sticky alignment flag
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_pc         <= RESET_PC;
            r_pend       <= 32'h0000_0000;
            r_ifid_instr <= NOP_INSTR;
            r_ifid_pc4   <= 32'h0000_0000;
            r_ifid_valid <= 1'b0;
            r_align_err  <= 1'b0;
        end else begin
            r_pc         <= w_pc_nxt;
            r_pend       <= w_pend_nxt;
            r_ifid_instr <= w_ifid_instr_nxt;
            r_ifid_pc4   <= w_ifid_pc4_nxt;
            r_ifid_valid <= w_ifid_valid_nxt;
            r_align_err  <= w_align_err_nxt;
        end
    end

    assign bus.InstrAddr       = r_pc;
    assign bus.IFID_Instr      = r_ifid_instr;
    assign bus.IFID_PCPlus4    = r_ifid_pc4;
    assign bus.IFID_Valid      = r_ifid_valid;
    assign bus.RedirectPending = (r_state == ST_PEND);
    assign bus.AlignErr        = r_align_err;

endmodule

`default_nettype wire

// File: tb/tb_pc_fetch_stage.sv
// ============================================================================
//  Module      : tb_pc_fetch_stage
//  Description : Scoreboard bench for pc_fetch_stage. Two instances: one with
//                RESET_PC=0 driven through directed vectors, one with
//                RESET_PC=0xFFFFFFF8 running free to cover PC wrap.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pc_fetch_stage;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] pc4;
        logic        v;
        logic        pend;
        logic        aerr;
    } exp_t;

    logic Clk;
    logic Reset;

    int   checks   = 0;
    int   failures = 0;

    exp_t qa[$];
    exp_t qb[$];

    pc_fetch_stage_if ifa ();
    pc_fetch_stage_if ifb ();

    pc_fetch_stage #(.RESET_PC(32'h0000_0000), .NOP_INSTR(32'h0000_0000)) u_dut_a (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (ifa.slave)
    );

    pc_fetch_stage #(.RESET_PC(32'hFFFF_FFF8), .NOP_INSTR(32'h0000_0000)) u_dut_b (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (ifb.slave)
    );

    // Instruction memory: each word is its address tagged in the top byte
    function automatic logic [31:0] memw(input logic [31:0] a);
        return a ^ 32'hA500_0000;
    endfunction

    assign ifa.Instruction = memw(ifa.InstrAddr);
    assign ifb.Instruction = memw(ifb.InstrAddr);

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    function automatic exp_t mk(input logic [31:0] pc, input logic [31:0] instr,
                                input logic [31:0] pc4, input logic v,
                                input logic pend, input logic aerr);
        exp_t e;
        e.pc = pc; e.instr = instr; e.pc4 = pc4; e.v = v; e.pend = pend; e.aerr = aerr;
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic cmp_a(input string tag, input exp_t e);
        chk({tag, ".InstrAddr"},       ifa.InstrAddr,              e.pc);
        chk({tag, ".IFID_Instr"},      ifa.IFID_Instr,             e.instr);
        chk({tag, ".IFID_PCPlus4"},    ifa.IFID_PCPlus4,           e.pc4);
        chk({tag, ".IFID_Valid"},      {31'd0, ifa.IFID_Valid},    {31'd0, e.v});
        chk({tag, ".RedirectPending"}, {31'd0, ifa.RedirectPending}, {31'd0, e.pend});
        chk({tag, ".AlignErr"},        {31'd0, ifa.AlignErr},      {31'd0, e.aerr});
    endtask

    task automatic cmp_b(input string tag, input exp_t e);
        chk({tag, ".InstrAddr"},    ifb.InstrAddr,           e.pc);
        chk({tag, ".IFID_Instr"},   ifb.IFID_Instr,          e.instr);
        chk({tag, ".IFID_PCPlus4"}, ifb.IFID_PCPlus4,        e.pc4);
        chk({tag, ".IFID_Valid"},   {31'd0, ifb.IFID_Valid}, {31'd0, e.v});
    endtask

    // Monitor: after every active edge, compare against the oldest expectation
    always @(posedge Clk) begin
        #1;
        if (qa.size() > 0) cmp_a("A", qa.pop_front());
        if (qb.size() > 0) cmp_b("B", qb.pop_front());
    end

    // Drive one cycle of inputs on the falling edge and queue the post-edge state
    task automatic step(input logic [1:0] src, input logic [31:0] nw,
                        input logic st, input exp_t e);
        @(negedge Clk);
        Reset           = 1'b1;
        ifa.PCSrc       = src;
        ifa.PCNew       = nw;
        ifa.Stall       = st;
        qa.push_back(e);
    endtask

    localparam logic [31:0] NOP = 32'h0000_0000;

    initial begin
        Reset     = 1'b0;
        ifa.PCSrc = 2'b00; ifa.PCNew = 32'h0; ifa.Stall = 1'b0;
        ifb.PCSrc = 2'b00; ifb.PCNew = 32'h0; ifb.Stall = 1'b0;

        #12;
        cmp_a("A.reset", mk(32'h0, NOP, 32'h0, 1'b0, 1'b0, 1'b0));
        chk("B.reset.InstrAddr", ifb.InstrAddr, 32'hFFFF_FFF8);

        // Sequential fetch from reset; instance B wraps through zero
        step(2'd0, 32'h0, 1'b0, mk(32'h04, memw(32'h00), 32'h04, 1'b1, 1'b0, 1'b0));
        qb.push_back(mk(32'hFFFF_FFFC, memw(32'hFFFF_FFF8), 32'hFFFF_FFFC, 1'b1, 1'b0, 1'b0));
        step(2'd0, 32'h0, 1'b0, mk(32'h08, memw(32'h04), 32'h08, 1'b1, 1'b0, 1'b0));
        qb.push_back(mk(32'h0000_0000, memw(32'hFFFF_FFFC), 32'h0000_0000, 1'b1, 1'b0, 1'b0));
        step(2'd0, 32'h0, 1'b0, mk(32'h0C, memw(32'h08), 32'h0C, 1'b1, 1'b0, 1'b0));
        qb.push_back(mk(32'h0000_0004, memw(32'h0000_0000), 32'h0000_0004, 1'b1, 1'b0, 1'b0));
        step(2'd0, 32'h0, 1'b0, mk(32'h10, memw(32'h0C), 32'h10, 1'b1, 1'b0, 1'b0));

        // Unstalled redirect at PC=0x10
        step(2'd1, 32'h40, 1'b0, mk(32'h40, NOP, 32'h10, 1'b0, 1'b0, 1'b0));
        step(2'd0, 32'h0,  1'b0, mk(32'h44, memw(32'h40), 32'h44, 1'b1, 1'b0, 1'b0));
        step(2'd1, 32'h1C, 1'b0, mk(32'h1C, NOP, 32'h44, 1'b0, 1'b0, 1'b0));
        step(2'd0, 32'h0,  1'b0, mk(32'h20, memw(32'h1C), 32'h20, 1'b1, 1'b0, 1'b0));

        // Three-cycle stall at PC=0x20 with a redirect on the second stall cycle
        step(2'd0, 32'h0,  1'b1, mk(32'h20, memw(32'h1C), 32'h20, 1'b1, 1'b0, 1'b0));
        step(2'd1, 32'h80, 1'b1, mk(32'h20, NOP, 32'h20, 1'b0, 1'b1, 1'b0));
        step(2'd0, 32'h0,  1'b1, mk(32'h20, NOP, 32'h20, 1'b0, 1'b1, 1'b0));
        step(2'd0, 32'h0,  1'b0, mk(32'h80, NOP, 32'h20, 1'b0, 1'b0, 1'b0));
        step(2'd0, 32'h0,  1'b0, mk(32'h84, memw(32'h80), 32'h84, 1'b1, 1'b0, 1'b0));

        // PCSrc 2 and 3 are sequential
        step(2'd2, 32'h300, 1'b0, mk(32'h88, memw(32'h84), 32'h88, 1'b1, 1'b0, 1'b0));
        step(2'd3, 32'h300, 1'b0, mk(32'h8C, memw(32'h88), 32'h8C, 1'b1, 1'b0, 1'b0));

        // Two redirects in one stall: newest pending target wins
        step(2'd1, 32'h100, 1'b1, mk(32'h8C, NOP, 32'h8C, 1'b0, 1'b1, 1'b0));
        step(2'd1, 32'h200, 1'b1, mk(32'h8C, NOP, 32'h8C, 1'b0, 1'b1, 1'b0));
        step(2'd0, 32'h0,   1'b0, mk(32'h200, NOP, 32'h8C, 1'b0, 1'b0, 1'b0));
        step(2'd0, 32'h0,   1'b0, mk(32'h204, memw(32'h200), 32'h204, 1'b1, 1'b0, 1'b0));

        // Unstalled redirect while pending overrides the pending target
        step(2'd1, 32'h100, 1'b1, mk(32'h204, NOP, 32'h204, 1'b0, 1'b1, 1'b0));
        step(2'd1, 32'h300, 1'b0, mk(32'h300, NOP, 32'h204, 1'b0, 1'b0, 1'b0));
        step(2'd0, 32'h0,   1'b0, mk(32'h304, memw(32'h300), 32'h304, 1'b1, 1'b0, 1'b0));

        // Misaligned target, sticky AlignErr
        step(2'd1, 32'h43, 1'b0, mk(32'h40, NOP, 32'h304, 1'b0, 1'b0, 1'b1));
        step(2'd0, 32'h0,  1'b0, mk(32'h44, memw(32'h40), 32'h44, 1'b1, 1'b0, 1'b1));
        step(2'd1, 32'h60, 1'b0, mk(32'h60, NOP, 32'h44, 1'b0, 1'b0, 1'b1));
        step(2'd1, 32'h70, 1'b1, mk(32'h60, NOP, 32'h44, 1'b0, 1'b1, 1'b1));

        // Asynchronous reset mid-PEND, between edges
        @(posedge Clk);
        #3;
        Reset = 1'b0;
        #1;
        cmp_a("A.async_reset", mk(32'h0, NOP, 32'h0, 1'b0, 1'b0, 1'b0));
        chk("B.async_reset.InstrAddr", ifb.InstrAddr, 32'hFFFF_FFF8);

        // After release the dropped pending target must not reappear
        step(2'd0, 32'h0, 1'b0, mk(32'h04, memw(32'h00), 32'h04, 1'b1, 1'b0, 1'b0));
        qb.push_back(mk(32'hFFFF_FFFC, memw(32'hFFFF_FFF8), 32'hFFFF_FFFC, 1'b1, 1'b0, 1'b0));

        @(posedge Clk);
        #3;
        chk("scoreboard_drained", qa.size() + qb.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Guard against a stuck run
    initial begin
        #50000;
        $display("FAIL timeout at %0t: got no finish expected finish", $time);
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
